// File: rtl/mempool_tcdm_responder.sv
// TCDM bank responder: request/response handshake, 1-cycle SRAM port, atomics as read-modify-write,
// fall-through response FIFO with credit-based request flow control.
module mempool_tcdm_responder #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BankAddrWidth = 10,
    parameter int unsigned RespDepth     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [AddrWidth-1:0]     data_qaddr_i,
    input  logic                     data_qwrite_i,
    input  logic [3:0]               data_qamo_i,
    input  logic [31:0]              data_qdata_i,
    input  logic [3:0]               data_qstrb_i,
    input  logic                     data_qvalid_i,
    output logic                     data_qready_o,
    output logic [31:0]              data_pdata_o,
    output logic                     data_perror_o,
    output logic                     data_pvalid_o,
    input  logic                     data_pready_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [BankAddrWidth-1:0] mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic [3:0]               mem_be_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int unsigned CntW = $clog2(RespDepth + 1);
    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoLr   = 4'hA;
    localparam logic [3:0] AmoSc   = 4'hB;

    typedef enum logic {IDLE, AMO_WR} state_e;

    state_e                   state;
    logic [CntW-1:0]          cnt;
    logic [CntW-1:0]          fifo_cnt;
    logic [PtrW-1:0]          wptr;
    logic [PtrW-1:0]          rptr;
    logic [31:0]              fifo_data [RespDepth];
    logic                     fifo_err  [RespDepth];
    logic                     res_valid;
    logic [BankAddrWidth-1:0] res_addr;
    logic                     pend_valid;
    logic                     pend_mem;
    logic                     pend_err;
    logic [31:0]              pend_data;
    logic [3:0]               amo_op;
    logic [31:0]              amo_opd;
    logic [BankAddrWidth-1:0] amo_addr;

    logic [BankAddrWidth-1:0] word_addr;
    logic accept, is_store, is_load, is_amo, is_lr, is_sc, atom_err, res_hit, take;
    logic [31:0] push_data;
    logic fifo_empty, pop, store_push, fifo_pop;
    logic req, we;
    logic unused_addr;

    function automatic logic [31:0] amo_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'h1:    r = b;
            4'h2:    r = a + b;
            4'h3:    r = a & b;
            4'h4:    r = a | b;
            4'h5:    r = a ^ b;
            4'h6:    r = ($signed(a) > $signed(b)) ? a : b;
            4'h7:    r = (a > b) ? a : b;
            4'h8:    r = ($signed(a) < $signed(b)) ? a : b;
            4'h9:    r = (a < b) ? a : b;
            default: r = a;
        endcase
        return r;
    endfunction

    assign unused_addr = ^data_qaddr_i[AddrWidth-1:BankAddrWidth+2];

    // Request decode; reserved opcodes C..F are answered as errors
    assign word_addr = data_qaddr_i[BankAddrWidth+1:2];
    assign accept    = data_qvalid_i & data_qready_o;
    assign is_store  = (data_qamo_i == AmoNone) & data_qwrite_i;
    assign is_load   = (data_qamo_i == AmoNone) & ~data_qwrite_i;
    assign is_amo    = (data_qamo_i >= 4'h1) & (data_qamo_i <= 4'h9);
    assign is_lr     = (data_qamo_i == AmoLr);
    assign is_sc     = (data_qamo_i == AmoSc);
    assign atom_err  = (data_qamo_i != AmoNone) &
                       ((data_qaddr_i[1:0] != 2'b00) | (data_qstrb_i != 4'hF) | (data_qamo_i > AmoSc));
    assign res_hit   = res_valid & (res_addr == word_addr);
    assign take      = accept & ~is_store;

    assign data_qready_o = rst_ni & (state == IDLE) & (cnt < CntW'(RespDepth));

    // Response path: FIFO head, or the response arriving this cycle when the FIFO is empty
    assign push_data     = pend_mem ? mem_rdata_i : pend_data;
    assign fifo_empty    = (fifo_cnt == '0);
    assign data_pvalid_o = rst_ni & (~fifo_empty | pend_valid);
    assign pop           = data_pvalid_o & data_pready_i;
    assign store_push    = rst_ni & pend_valid & ~(fifo_empty & data_pready_i);
    assign fifo_pop      = ~fifo_empty & data_pready_i;

    always_comb begin
        data_pdata_o  = '0;
        data_perror_o = 1'b0;
        if (data_pvalid_o) begin
            if (fifo_empty) begin
                data_pdata_o  = push_data;
                data_perror_o = pend_err;
            end else begin
                data_pdata_o  = fifo_data[rptr];
                data_perror_o = fifo_err[rptr];
            end
        end
    end

    // SRAM port: AMO write-back owns the port in AMO_WR, otherwise the accepted request
    always_comb begin
        req         = 1'b0;
        we          = 1'b0;
        mem_addr_o  = word_addr;
        mem_wdata_o = data_qdata_i;
        mem_be_o    = data_qstrb_i;
        if (state == AMO_WR) begin
            req         = 1'b1;
            we          = 1'b1;
            mem_addr_o  = amo_addr;
            mem_wdata_o = amo_alu(amo_op, mem_rdata_i, amo_opd);
            mem_be_o    = 4'hF;
        end else if (accept) begin
            if (is_store) begin
                req = 1'b1;
                we  = 1'b1;
            end else if (is_load) begin
                req = 1'b1;
            end else if (!atom_err) begin
                if (is_amo || is_lr) begin
                    req = 1'b1;
                end else if (is_sc && res_hit) begin
                    req = 1'b1;
                    we  = 1'b1;
                end
            end
        end
    end

    assign mem_req_o = rst_ni & req;
    assign mem_we_o  = rst_ni & we;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            fifo_cnt   <= '0;
            wptr       <= '0;
            rptr       <= '0;
            res_valid  <= 1'b0;
            res_addr   <= '0;
            pend_valid <= 1'b0;
            pend_mem   <= 1'b0;
            pend_err   <= 1'b0;
            pend_data  <= '0;
            amo_op     <= '0;
            amo_opd    <= '0;
            amo_addr   <= '0;
        end else begin
            pend_valid <= take;
            pend_mem   <= 1'b0;
            pend_err   <= 1'b0;
            pend_data  <= '0;
            if (take) begin
                if (atom_err) begin
                    pend_err <= 1'b1;
                end else if (is_sc) begin
                    pend_data <= res_hit ? 32'd0 : 32'd1;
                end else begin
                    pend_mem <= 1'b1;
                end
            end

            cnt      <= cnt + CntW'(take) - CntW'(pop);
            fifo_cnt <= fifo_cnt + CntW'(store_push) - CntW'(fifo_pop);
            if (store_push) wptr <= (wptr == PtrW'(RespDepth - 1)) ? '0 : wptr + PtrW'(1);
            if (fifo_pop)   rptr <= (rptr == PtrW'(RespDepth - 1)) ? '0 : rptr + PtrW'(1);

            case (state)
                IDLE: begin
                    if (accept && !atom_err) begin
                        if (is_amo) begin
                            state    <= AMO_WR;
                            amo_op   <= data_qamo_i;
                            amo_opd  <= data_qdata_i;
                            amo_addr <= word_addr;
                        end
                        if ((is_store && res_hit) || is_sc) begin
                            res_valid <= 1'b0;
                        end else if (is_lr) begin
                            res_valid <= 1'b1;
                            res_addr  <= word_addr;
                        end
                    end
                end
                AMO_WR: begin
                    state <= IDLE;
                    if (res_valid && (res_addr == amo_addr)) res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted as occupied
    always_ff @(posedge clk_i) begin
        if (store_push) begin
            fifo_data[wptr] <= push_data;
            fifo_err[wptr]  <= pend_err;
        end
    end

endmodule

// File: tb/tb_mempool_tcdm_responder.sv
// Scoreboard bench for mempool_tcdm_responder: directed requests push expected responses,
// a negedge monitor pops and compares every handshaken response.
module tb_mempool_tcdm_responder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] qaddr = '0;
    logic        qwrite = 1'b0;
    logic [3:0]  qamo = '0;
    logic [31:0] qdata = '0;
    logic [3:0]  qstrb = '0;
    logic        qvalid = 1'b0;
    logic        qready;
    logic [31:0] pdata;
    logic        perror;
    logic        pvalid;
    logic        pready = 1'b1;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] sb[$];
    logic [31:0] sram [1024];
    int unsigned acc_cnt = 0;

    mempool_tcdm_responder #(.AddrWidth(32), .BankAddrWidth(10), .RespDepth(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .data_qaddr_i(qaddr), .data_qwrite_i(qwrite), .data_qamo_i(qamo),
        .data_qdata_i(qdata), .data_qstrb_i(qstrb), .data_qvalid_i(qvalid),
        .data_qready_o(qready), .data_pdata_o(pdata), .data_perror_o(perror),
        .data_pvalid_o(pvalid), .data_pready_i(pready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro model with 1-cycle read latency
    always @(posedge clk) begin
        if (mem_req) begin
            acc_cnt <= acc_cnt + 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (pvalid && pready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {31'd0, perror, pdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("resp", {31'd0, perror, pdata}, {31'd0, e});
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] amo,
                         input logic [31:0] data, input logic [3:0] strb, input logic has_resp,
                         input logic [32:0] exp, output int waits);
        waits = 0;
        @(negedge clk);
        qaddr = addr; qwrite = wr; qamo = amo; qdata = data; qstrb = strb; qvalid = 1'b1;
        while (!qready) begin
            @(negedge clk);
            waits++;
            if (waits > 100) begin
                check("accept_timeout", 64'(waits), 64'd0);
                qvalid = 1'b0;
                return;
            end
        end
        if (has_resp) sb.push_back(exp);
        @(posedge clk);
        #1 qvalid = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] exp);
        int w;
        issue(addr, 1'b0, 4'h0, 32'd0, 4'hF, 1'b1, {1'b0, exp}, w);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int w;
        issue(addr, 1'b1, 4'h0, data, strb, 1'b0, 33'd0, w);
    endtask

    task automatic atomic(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_old);
        int w;
        issue(addr, 1'b0, op, data, 4'hF, 1'b1, {1'b0, exp_old}, w);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 || pvalid) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2;
        int unsigned acc0;

        repeat (3) @(negedge clk);
        check("rst_qready", 64'(qready), 64'd0);
        check("rst_pvalid", 64'(pvalid), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_pdata", {31'd0, perror, pdata}, 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("idle_qready", 64'(qready), 64'd1);

        store(32'h00, 32'hA5A5_A5A5, 4'hF);
        store(32'h40, 32'h1122_3344, 4'hF);
        store(32'h14, 32'h7FFF_FFFF, 4'hF);
        store(32'h20, 32'h0000_0055, 4'hF);

        // Partial store then load, response visible the cycle after acceptance
        store(32'h40, 32'hDEAD_BEEF, 4'b0011);
        load(32'h40, 32'h1122_BEEF);
        check("load_latency_pvalid", 64'(pvalid), 64'd1);
        check("load_latency_pdata", 64'(pdata), 64'h1122_BEEF);
        drain();

        // Credit back-pressure with pready held low
        @(posedge clk); #1 pready = 1'b0;
        load(32'h40, 32'h1122_BEEF);
        load(32'h14, 32'h7FFF_FFFF);
        fork
            begin
                issue(32'h00, 1'b0, 4'h0, 32'd0, 4'hF, 1'b1, {1'b0, 32'hA5A5_A5A5}, w);
                check("bp_third_waited", 64'(w >= 3), 64'd1);
            end
            begin
                repeat (2) @(negedge clk);
                check("bp_qready_low", 64'(qready), 64'd0);
                check("bp_hold_pdata0", 64'(pdata), 64'h1122_BEEF);
                @(negedge clk);
                check("bp_hold_pvalid", 64'(pvalid), 64'd1);
                check("bp_hold_pdata1", 64'(pdata), 64'h1122_BEEF);
                @(posedge clk); #1 pready = 1'b1;
            end
        join
        drain();

        // AMO chain on word 5
        atomic(4'h2, 32'h14, 32'h0000_0001, 32'h7FFF_FFFF);
        atomic(4'h6, 32'h14, 32'hFFFF_FFFF, 32'h8000_0000);
        atomic(4'h9, 32'h14, 32'h0000_0005, 32'hFFFF_FFFF);
        load(32'h14, 32'h0000_0005);
        atomic(4'h5, 32'h14, 32'h0000_00F0, 32'h0000_0005);
        atomic(4'h3, 32'h14, 32'h0000_000F, 32'h0000_00F5);
        atomic(4'h1, 32'h14, 32'h1234_5678, 32'h0000_0005);
        atomic(4'h8, 32'h14, 32'h8000_0000, 32'h1234_5678);
        atomic(4'h7, 32'h14, 32'h0000_0001, 32'h8000_0000);
        atomic(4'h4, 32'h14, 32'h0000_0001, 32'h8000_0000);
        load(32'h14, 32'h8000_0001);
        drain();

        // LR/SC reservation handling
        atomic(4'hA, 32'h20, 32'd0, 32'h0000_0055);
        atomic(4'hB, 32'h20, 32'h0000_0007, 32'd0);
        load(32'h20, 32'h0000_0007);
        atomic(4'hB, 32'h20, 32'h0000_0009, 32'd1);
        load(32'h20, 32'h0000_0007);
        atomic(4'hA, 32'h20, 32'd0, 32'h0000_0007);
        store(32'h20, 32'h0000_0099, 4'hF);
        atomic(4'hB, 32'h20, 32'h0000_00AA, 32'd1);
        load(32'h20, 32'h0000_0099);
        drain();

        // Misaligned / partial-strobe atomics answer with an error and leave the SRAM alone
        acc0 = acc_cnt;
        issue(32'h21, 1'b0, 4'h1, 32'h1, 4'hF, 1'b1, {1'b1, 32'd0}, w);
        issue(32'h20, 1'b0, 4'h0, 32'd0, 4'hF, 1'b1, {1'b0, 32'h99}, w2);
        check("err_next_accept", 64'(w2), 64'd0);
        check("err_no_sram", 64'(acc_cnt), 64'(acc0 + 1));
        issue(32'h20, 1'b0, 4'hA, 32'd0, 4'h7, 1'b1, {1'b1, 32'd0}, w);
        issue(32'h22, 1'b0, 4'hB, 32'h5, 4'hF, 1'b1, {1'b1, 32'd0}, w);
        atomic(4'hB, 32'h20, 32'h0000_0011, 32'd1);
        load(32'h20, 32'h0000_0099);
        drain();

        // Reset during AMO write-back cycle
        issue(32'h14, 1'b0, 4'h2, 32'h5, 4'hF, 1'b0, 33'd0, w);
        rst_ni = 1'b0;
        @(negedge clk);
        check("amo_rst_mem_req", 64'(mem_req), 64'd0);
        check("amo_rst_pvalid", 64'(pvalid), 64'd0);
        check("amo_rst_qready", 64'(qready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("post_rst_qready", 64'(qready), 64'd1);
        @(posedge clk); #1 pready = 1'b0;
        issue(32'h14, 1'b0, 4'h0, 32'd0, 4'hF, 1'b1, {1'b0, 32'h8000_0001}, w);
        check("post_rst_credit0", 64'(w), 64'd0);
        issue(32'h00, 1'b0, 4'h0, 32'd0, 4'hF, 1'b1, {1'b0, 32'hA5A5_A5A5}, w);
        check("post_rst_credit1", 64'(w), 64'd0);
        @(negedge clk);
        check("post_rst_full", 64'(qready), 64'd0);
        @(posedge clk); #1 pready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
